// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master_rtl between N_REQ requesters.
// Grants one requester, pulses send, tracks the busy handshake and returns the response.
module spi_txn_arbiter #(
   parameter int unsigned BITS     = 28,
   parameter int unsigned N_REQ    = 3,
   parameter int unsigned SEL_W    = $clog2(N_REQ),
   parameter int unsigned START_TO = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*BITS-1:0]   i_req_data,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [N_REQ-1:0]        o_done,
   output logic                    o_err,
   output logic [BITS-1:0]         o_rsp_data,
   output logic [SEL_W-1:0]        o_sel,
   output logic [BITS-1:0]         o_m_data,
   output logic                    o_m_send,
   input  logic                    i_m_busy,
   input  logic [BITS-1:0]         i_m_data
);

   localparam int unsigned CNT_W = $clog2(START_TO + 1);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      COMPLETE
   } state_t;

   state_t             state;
   state_t             state_d;
   logic [N_REQ-1:0]   gnt_d;
   logic [N_REQ-1:0]   done_d;
   logic               err_d;
   logic               send_d;
   logic [BITS-1:0]    rsp_d;
   logic [BITS-1:0]    m_data_d;
   logic [SEL_W-1:0]   sel_d;
   logic [SEL_W-1:0]   ptr;
   logic [SEL_W-1:0]   ptr_d;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_d;

   logic [BITS-1:0]    req_word [N_REQ];
   logic               win_ok;
   logic [SEL_W-1:0]   win;
   logic [SEL_W-1:0]   cand;
   int unsigned        pos;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign req_word[g] = i_req_data[g*BITS +: BITS];
   end

   // Round-robin search: first requester at or above the pointer, wrapping.
   always_comb begin
      win_ok = 1'b0;
      win    = '0;
      cand   = '0;
      pos    = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         pos  = (32'(ptr) + i) % N_REQ;
         cand = SEL_W'(pos);
         if (!win_ok && i_req[cand]) begin
            win_ok = 1'b1;
            win    = cand;
         end
      end
   end

   always_comb begin
      state_d  = state;
      gnt_d    = o_gnt;
      sel_d    = o_sel;
      m_data_d = o_m_data;
      rsp_d    = o_rsp_data;
      ptr_d    = ptr;
      cnt_d    = cnt;
      send_d   = 1'b0;
      done_d   = '0;
      err_d    = 1'b0;
      unique case (state)
         IDLE: begin
            // The master must be idle before a new transaction is granted.
            if (win_ok && !i_m_busy) begin
               gnt_d    = N_REQ'(1) << win;
               sel_d    = win;
               m_data_d = req_word[win];
               send_d   = 1'b1;
               state_d  = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (i_m_busy) begin
               state_d = WAIT_DONE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
               if (cnt_d == CNT_W'(START_TO)) begin
                  rsp_d   = '0;
                  done_d  = o_gnt;
                  err_d   = 1'b1;
                  state_d = COMPLETE;
               end
            end
         end
         WAIT_DONE: begin
            if (!i_m_busy) begin
               rsp_d   = i_m_data;
               done_d  = o_gnt;
               state_d = COMPLETE;
            end
         end
         COMPLETE: begin
            gnt_d   = '0;
            ptr_d   = (o_sel == SEL_W'(N_REQ - 1)) ? '0 : o_sel + SEL_W'(1);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         o_gnt      <= '0;
         o_done     <= '0;
         o_err      <= 1'b0;
         o_m_send   <= 1'b0;
         o_sel      <= '0;
         o_m_data   <= '0;
         o_rsp_data <= '0;
         ptr        <= '0;
         cnt        <= '0;
      end else begin
         state      <= state_d;
         o_gnt      <= gnt_d;
         o_done     <= done_d;
         o_err      <= err_d;
         o_m_send   <= send_d;
         o_sel      <= sel_d;
         o_m_data   <= m_data_d;
         o_rsp_data <= rsp_d;
         ptr        <= ptr_d;
         cnt        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: directed phases, a transaction-level reference model
// compared every cycle, and literal expectations on the model's event logs.
module tb_spi_txn_arbiter;

   localparam int unsigned BITS     = 28;
   localparam int unsigned N_REQ    = 3;
   localparam int unsigned SEL_W    = 2;
   localparam int unsigned START_TO = 16;
   localparam int          BUSY_LEN = 4;

   logic                  clk;
   logic                  rst;
   logic [N_REQ-1:0]      req;
   logic [N_REQ*BITS-1:0] req_data;
   logic [N_REQ-1:0]      gnt;
   logic [N_REQ-1:0]      done;
   logic                  err;
   logic [BITS-1:0]       rsp_data;
   logic [SEL_W-1:0]      sel;
   logic [BITS-1:0]       m_data;
   logic                  m_send;
   logic                  m_busy;
   logic [BITS-1:0]       m_rdata;

   spi_txn_arbiter #(
      .BITS(BITS), .N_REQ(N_REQ), .SEL_W(SEL_W), .START_TO(START_TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
      .o_gnt(gnt), .o_done(done), .o_err(err), .o_rsp_data(rsp_data),
      .o_sel(sel), .o_m_data(m_data), .o_m_send(m_send),
      .i_m_busy(m_busy), .i_m_data(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus controls read by the master model and the checker.
   int   phase;
   logic force_busy;
   logic dead_master;
   logic fin;
   int   tmo_cnt;

   int   checks;
   int   failures;
   int   cyc;

   typedef struct { int ph; int idx; int cyc; } gev_t;
   typedef struct { int ph; int idx; int err; int rsp; int lat; } dev_t;
   gev_t glog[$];
   dev_t dlog[$];

   // Master model: busy for BUSY_LEN cycles after a send, then returns ~word.
   int              m_cnt;
   logic [BITS-1:0] m_word;
   initial begin
      m_busy  = 1'b0;
      m_rdata = '0;
      m_cnt   = 0;
      m_word  = '0;
      forever begin
         @(negedge clk);
         #1;
         if (!dead_master && m_send) begin
            m_cnt  = BUSY_LEN;
            m_word = ~m_data;
         end else if (m_cnt > 0) begin
            m_cnt--;
         end
         m_busy  = force_busy || (m_cnt > 0);
         m_rdata = (m_cnt > 0) ? 28'h5A5A5A5 : m_word;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d act=0x%0h exp=0x%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic int g_idx(input int p, input int n);
      int c = 0;
      foreach (glog[i]) if (glog[i].ph == p) begin
         if (c == n) return glog[i].idx;
         c++;
      end
      return -1;
   endfunction

   function automatic int g_cyc(input int p, input int n);
      int c = 0;
      foreach (glog[i]) if (glog[i].ph == p) begin
         if (c == n) return glog[i].cyc;
         c++;
      end
      return -1;
   endfunction

   function automatic dev_t d_at(input int p, input int n);
      dev_t d = '{ph: -1, idx: -1, err: -1, rsp: -1, lat: -1};
      int c = 0;
      foreach (dlog[i]) if (dlog[i].ph == p) begin
         if (c == n) return dlog[i];
         c++;
      end
      return d;
   endfunction

   function automatic int n_done(input int p, input int idx);
      int c = 0;
      foreach (dlog[i]) if (dlog[i].ph == p && dlog[i].idx == idx) c++;
      return c;
   endfunction

   // Reference model state (transaction level) and expected outputs.
   logic                  s_rst, s_busy, s_force, prev_force;
   logic [N_REQ-1:0]      s_req;
   logic [BITS-1:0]       s_mdata;
   logic [BITS-1:0]       s_word [N_REQ];
   int  m_ptr, m_idx, m_age, send_cyc, fall_cyc;
   bit  m_active, m_fin, m_seen, found;
   logic [N_REQ-1:0] e_gnt, e_done;
   logic [SEL_W-1:0] e_sel;
   logic [BITS-1:0]  e_mdata, e_rsp;
   logic             e_send, e_err;
   dev_t             d;

   initial begin
      checks = 0; failures = 0; cyc = 0;
      m_ptr = 0; m_idx = 0; m_age = 0; send_cyc = 0; fall_cyc = -1;
      m_active = 0; m_fin = 0; m_seen = 0; prev_force = 0;
      e_gnt = '0; e_done = '0; e_sel = '0; e_mdata = '0; e_rsp = '0; e_send = 0; e_err = 0;
      forever begin
         @(posedge clk);
         cyc++;
         s_rst = rst; s_req = req; s_busy = m_busy; s_mdata = m_rdata; s_force = force_busy;
         for (int j = 0; j < int'(N_REQ); j++) s_word[j] = req_data[j*BITS +: BITS];
         if (prev_force && !s_force) fall_cyc = cyc;
         prev_force = s_force;

         e_send = 1'b0; e_done = '0; e_err = 1'b0;
         if (s_rst) begin
            m_active = 0; m_fin = 0; m_ptr = 0;
            e_gnt = '0; e_sel = '0; e_mdata = '0; e_rsp = '0;
         end else if (m_fin) begin
            m_fin = 0; m_active = 0; e_gnt = '0;
            m_ptr = (m_idx + 1) % int'(N_REQ);
         end else if (!m_active) begin
            if (s_req != '0 && !s_busy) begin
               found = 0;
               for (int j = 0; j < int'(N_REQ); j++) begin
                  if (!found && s_req[(m_ptr + j) % int'(N_REQ)]) begin
                     found = 1;
                     m_idx = (m_ptr + j) % int'(N_REQ);
                  end
               end
               m_active = 1; m_age = 0; m_seen = 0;
               e_gnt = N_REQ'(1) << m_idx; e_sel = SEL_W'(m_idx);
               e_mdata = s_word[m_idx]; e_send = 1'b1;
            end
         end else begin
            // Edge 1 after grant ends the send cycle; from edge 2 busy is watched.
            m_age++;
            if (m_age >= 2) begin
               if (!m_seen) begin
                  if (s_busy) m_seen = 1;
                  else if (m_age - 1 == int'(START_TO)) begin
                     e_done = e_gnt; e_err = 1'b1; e_rsp = '0; m_fin = 1;
                  end
               end else if (!s_busy) begin
                  e_done = e_gnt; e_rsp = s_mdata; m_fin = 1;
               end
            end
         end

         #1;
         chk("gnt", 32'(gnt), 32'(e_gnt));
         chk("send", 32'(m_send), 32'(e_send));
         chk("done", 32'(done), 32'(e_done));
         chk("err", 32'(err), 32'(e_err));
         chk("rsp", 32'(rsp_data), 32'(e_rsp));
         if (e_gnt != '0 || s_rst) begin
            chk("sel", 32'(sel), 32'(e_sel));
            chk("mdata", 32'(m_data), 32'(e_mdata));
         end

         if (e_send) begin
            glog.push_back('{ph: phase, idx: m_idx, cyc: cyc});
            send_cyc = cyc;
         end
         if (e_done != '0)
            dlog.push_back('{ph: phase, idx: m_idx, err: int'(e_err), rsp: 32'(e_rsp), lat: cyc - send_cyc});

         if (fin || cyc > 5000) begin
            chk("fin_flag", 32'(fin), 1);
            chk("wait_timeouts", tmo_cnt, 0);
            chk("p1_grant", g_idx(1, 0), 0);
            d = d_at(1, 0);
            chk("p1_rsp", d.rsp, 32'h0F543210);
            chk("p1_err", d.err, 0);
            chk("p1_lat", d.lat, 5);
            chk("p2_first", g_idx(2, 0), 2);
            chk("p2_second", g_idx(2, 1), 0);
            for (int k = 0; k < 6; k++) chk($sformatf("p3_order%0d", k), g_idx(3, k), k % 3);
            d = d_at(4, 0);
            chk("p4_err", d.err, 1);
            chk("p4_rsp", d.rsp, 0);
            chk("p4_lat", d.lat, 17);
            d = d_at(5, 0);
            chk("p5_err", d.err, 0);
            chk("p5_rsp", d.rsp, 32'h0EDCBA98);
            chk("p6_grant", g_idx(6, 0), 1);
            chk("p6_gnt_cyc", g_cyc(6, 0), fall_cyc);
            chk("p78_no_done2", n_done(7, 2) + n_done(8, 2), 0);
            chk("p8_grant", g_idx(8, 0), 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   task automatic wait_gnt(input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (gnt == '0 && n < lim);
      if (gnt == '0) tmo_cnt++;
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (done == '0 && n < lim);
      if (done == '0) tmo_cnt++;
   endtask

   initial begin
      phase = 0; force_busy = 1'b0; dead_master = 1'b0; fin = 1'b0; tmo_cnt = 0;
      rst = 1'b1; req = '0; req_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single request; request and data dropped mid-transaction.
      phase = 1;
      req_data[0*BITS +: BITS] = 28'h0ABCDEF;
      req = 3'b001;
      wait_gnt(10);
      @(negedge clk);
      req = 3'b000;
      req_data[0*BITS +: BITS] = 28'h7777777;
      wait_done(20);
      repeat (2) @(negedge clk);

      // Pointer at 1: requester 2 wins over 0.
      phase = 2;
      req_data[0*BITS +: BITS] = 28'h1111111;
      req_data[2*BITS +: BITS] = 28'h2222222;
      req = 3'b101;
      wait_done(20);
      req[2] = 1'b0;
      wait_done(20);
      req = '0;
      repeat (2) @(negedge clk);

      // From reset, all requesters held for six transactions.
      phase = 3;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         wait_done(20);
         req_data = req_data + {N_REQ{28'h0100101}};
      end
      req = '0;
      repeat (2) @(negedge clk);

      // Master never raises busy: start timeout.
      phase = 4;
      dead_master = 1'b1;
      req = 3'b010;
      wait_done(40);
      req = '0;
      dead_master = 1'b0;
      @(negedge clk);

      phase = 5;
      req_data[1*BITS +: BITS] = 28'h1234567;
      req = 3'b010;
      wait_done(20);
      req = '0;
      repeat (2) @(negedge clk);

      // Master busy at request time.
      phase = 6;
      force_busy = 1'b1;
      req = 3'b010;
      repeat (4) @(negedge clk);
      force_busy = 1'b0;
      wait_done(20);
      req = '0;
      repeat (2) @(negedge clk);

      // Reset while waiting for busy to fall.
      phase = 7;
      req_data[2*BITS +: BITS] = 28'h3C3C3C3;
      req = 3'b100;
      wait_gnt(10);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      phase = 8;
      req = 3'b111;
      wait_done(30);
      req = '0;
      repeat (4) @(negedge clk);

      fin = 1'b1;
      repeat (5) @(negedge clk);
      $display("FAIL end_handshake act=running exp=finished");
      $fatal(1, "checker did not finish");
   end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one spi_master_rtl between N_REQ requesters, each bound to one SPI exe unit.
- Grants one requester at a time and drives the slave-select index (MISO mux / slave routing).
- Launches the master with a one-cycle send pulse, tracks the busy handshake, then returns the received word with a per-requester done pulse.
- Sits between the system-side requesters and spi_master_rtl.

Parameters:
BITS, 28, SPI frame width (matches spi_master_rtl)
N_REQ, 3, number of requesters/slaves (>=2)
SEL_W, $clog2(N_REQ), width of slave-select index
START_TO, 16, max cycles from send pulse to master busy before abort

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_req  in  N_REQ  per-requester transfer request, level, held until o_done
i_req_data  in  N_REQ*BITS  request words, requester k at [k*BITS +: BITS]
o_gnt  out  N_REQ  one-hot grant, high from grant until completion
o_done  out  N_REQ  one-cycle completion pulse for granted requester
o_err  out  1  one-cycle pulse with o_done when the start timeout aborted
o_rsp_data  out  BITS  received word, valid in o_done cycle, held until next completion
o_sel  out  SEL_W  index of granted slave, stable for the whole transaction
o_m_data  out  BITS  word to master i_data, latched at grant
o_m_send  out  1  send pulse to master i_send
i_m_busy  in  1  master o_busy
i_m_data  in  BITS  master o_data

Behaviour:
- Reset (i_rst=1 at an edge) forces IDLE and clears o_gnt, o_done, o_err, o_m_send, o_sel, o_m_data, o_rsp_data, the timeout counter and the RR pointer (pointer=0).
- Reset mid-transaction abandons the transaction: no done pulse is issued and the master is not waited on.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE:
  - If i_req!=0 and i_m_busy=0, pick the first set bit searching from the pointer upward with wrap (pointer, pointer+1, ... N_REQ-1, 0, ...).
  - Register o_gnt/o_sel for the winner and latch o_m_data from its slice, then go to LAUNCH.
  - If i_m_busy=1, stay in IDLE; the master must be idle before any grant.
- LAUNCH: o_m_send=1 for exactly this cycle, o_m_data stable; counter cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - If i_m_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TO, set err_flag and go to COMPLETE.
- WAIT_DONE: on i_m_busy=0, capture i_m_data into o_rsp_data and go to COMPLETE.
- COMPLETE:
  - o_done[idx]=1 and o_err=err_flag for one cycle.
  - On abort, o_rsp_data is set to 0.
  - o_gnt cleared on exit.
  - Pointer is updated to (idx+1) mod N_REQ; state returns to IDLE.
- Latency:
  - req seen at IDLE edge t: grant visible t+1, send pulse during t+1..t+2.
  - done pulse asserted one cycle after the edge at which busy-fall is sampled.
  - Minimum IDLE-to-IDLE gap is 1 cycle, so a new grant can be issued the cycle after COMPLETE.
- Requests:
  - Deasserting i_req of the granted requester mid-transaction is ignored; the transfer completes and done still pulses.
  - A request dropped before being granted is never granted.
  - i_req_data changes after grant have no effect.
- Simultaneous requests: strict round-robin from the pointer. With all bits held high, grant order is 0,1,2,0,...
- o_sel, o_gnt and o_m_data never change between grant and COMPLETE.
- At most one o_gnt bit and at most one o_done bit is ever high.

Test Plan:
- Single request: i_req=001, data0=0x0ABCDEF, master model echoes ~data (BITS) -> o_m_send 1 cycle after grant, o_sel=0, o_done=001 one cycle, o_rsp_data=~0x0ABCDEF & 0xFFFFFFF, o_err=0.
- All requesters held (i_req=111) for 6 transactions from reset -> grant order 0,1,2,0,1,2; o_sel matches each grant and is constant within each transaction.
- Pointer fairness: pointer=1 after one transfer by 0, then i_req=101 -> requester 2 granted before 0.
- Start timeout: master model never raises busy -> exactly START_TO=16 WAIT_BUSY cycles later o_done pulses with o_err=1, o_rsp_data=0; next request is served normally.
- Master busy at request: i_m_busy=1 with i_req=010 -> no grant until busy falls, then grant on the following edge.
- Reset in WAIT_DONE: assert i_rst one cycle -> all outputs 0, no o_done; fresh request afterwards is granted to requester 0 first when i_req=111.
